dreg_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared WIDTH-bit D-flip-flop data register. Up to NREQ requesters contend for the register. The arbiter grants exactly one requester at a time and loads that requester's data into the register on every clock edge while the grant is held. It sits between the requesting lab datapaths and the shared d_ff bank, and is the only writer of that bank.

---
 rtl/dreg_arbiter.sv | 137 +++++++++++++
 tb/tb_dreg_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dreg_arbiter.sv
// Round-robin arbiter and sequencer; the only writer of the shared WIDTH-bit register.
// Define DREG_ARB_TIMEOUT_EN to cap every grant at MAX_HOLD loads.
module dreg_arbiter #(
  parameter int  NREQ     = 4,
  parameter int  WIDTH    = 8,
  parameter int  MAX_HOLD = 8,
  localparam int OW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [OW-1:0]         owner,
  output logic [WIDTH-1:0]      q,
  output logic                  q_wr
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_n;
  logic [NREQ-1:0]  gnt_n;
  logic [OW-1:0]    owner_n;
  logic [WIDTH-1:0] q_n;
  logic             q_wr_n;
  logic [OW-1:0]    ptr, ptr_n, ptr_adv;
  logic [OW-1:0]    pick;
  logic             found;
  logic [WIDTH-1:0] sel_data;
  logic             own_req;

`ifdef DREG_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] cnt, cnt_n;
`endif

  if (NREQ < 2 || NREQ > 8 || MAX_HOLD < 1) begin : g_bad_params
    $error("dreg_arbiter: NREQ must be 2..8 and MAX_HOLD at least 1");
  end

  function automatic logic [OW-1:0] wrap_idx(input logic [OW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NREQ;
    return OW'(s);
  endfunction

  // Scan downward so the lowest offset from the pointer is the one left standing.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[wrap_idx(ptr, k)]) begin
        found = 1'b1;
        pick  = wrap_idx(ptr, k);
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == OW'(i)) sel_data = wdata[i*WIDTH +: WIDTH];
    end
  end

  assign own_req = req[owner];
  assign ptr_adv = (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    owner_n = owner;
    q_n     = q;
    q_wr_n  = 1'b0;
    ptr_n   = ptr;
`ifdef DREG_ARB_TIMEOUT_EN
    cnt_n   = cnt;
`endif
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          gnt_n   = NREQ'(1) << pick;
          owner_n = pick;
`ifdef DREG_ARB_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end
      end
      GRANT: begin
        if (own_req) begin
          q_n    = sel_data;
          q_wr_n = 1'b1;
`ifdef DREG_ARB_TIMEOUT_EN
          cnt_n  = cnt + 1'b1;
          // The load that reaches the hold limit also ends the grant.
          if (cnt_n == CW'(MAX_HOLD)) begin
            state_n = IDLE;
            gnt_n   = '0;
            ptr_n   = ptr_adv;
          end
`endif
        end else begin
          state_n = IDLE;
          gnt_n   = '0;
          ptr_n   = ptr_adv;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      q     <= '0;
      q_wr  <= 1'b0;
      ptr   <= '0;
`ifdef DREG_ARB_TIMEOUT_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      owner <= owner_n;
      q     <= q_n;
      q_wr  <= q_wr_n;
      ptr   <= ptr_n;
`ifdef DREG_ARB_TIMEOUT_EN
      cnt   <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_dreg_arbiter.sv
// Scoreboard bench for dreg_arbiter: a behavioural model queues expected outputs per edge,
// and directed checks cover reset, single transfer, wrap, fairness, mid-grant reset and long holds.
module tb_dreg_arbiter;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 8;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic [7:0]  q;
  logic        q_wr;

  dreg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .gnt(gnt), .owner(owner), .q(q), .q_wr(q_wr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] owner;
    logic [7:0] q;
    logic       qwr;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  bit         m_busy;
  logic [3:0] m_gnt;
  int         m_owner;
  logic [7:0] m_q;
  bit         m_qwr;
  int         m_ptr;
  int         m_cnt;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelRelease();
    m_busy = 1'b0;
    m_gnt  = 4'b0000;
    m_ptr  = (m_owner + 1) % NREQ;
  endtask

  // Predicts the register values after the edge that samples these inputs.
  task automatic modelEdge(input logic r, input logic [3:0] rq, input logic [31:0] wd);
    bit hit;
    int i;
    if (r) begin
      m_busy = 1'b0; m_gnt = 4'b0000; m_owner = 0; m_q = 8'h00;
      m_qwr = 1'b0; m_ptr = 0; m_cnt = 0;
    end else if (!m_busy) begin
      m_qwr = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (!hit && rq[i]) begin
          hit = 1'b1; m_busy = 1'b1; m_owner = i;
          m_gnt = 4'b0001 << i; m_cnt = 0;
        end
      end
    end else begin
      if (rq[m_owner]) begin
        m_q   = wd[m_owner*8 +: 8];
        m_qwr = 1'b1;
        m_cnt++;
`ifdef DREG_ARB_TIMEOUT_EN
        if (m_cnt == MAX_HOLD) modelRelease();
`endif
      end else begin
        m_qwr = 1'b0;
        modelRelease();
      end
    end
  endtask

  task automatic scoreboardCheck();
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput("sb_gnt",   32'(gnt),   32'(e.gnt));
      checkOutput("sb_owner", 32'(owner), 32'(e.owner));
      checkOutput("sb_q",     32'(q),     32'(e.q));
      checkOutput("sb_q_wr",  32'(q_wr),  32'(e.qwr));
    end
  endtask

  // On return the visible outputs are those of the edge before the inputs just driven.
  task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [31:0] wd);
    exp_t e;
    @(negedge clk);
    scoreboardCheck();
    rst   = r;
    req   = rq;
    wdata = wd;
    modelEdge(r, rq, wd);
    e.gnt   = m_gnt;
    e.owner = 2'(m_owner);
    e.q     = m_q;
    e.qwr   = m_qwr;
    sb.push_back(e);
  endtask

  initial begin
    logic [3:0] rq;
    logic [3:0] prev;
    int         order[$];
    int         gaps[$];
    int         gap;
    bit         seen;
    int         exp_order[5];

    rst = 1'b1; req = 4'h0; wdata = 32'h0;
    exp_order = '{0, 1, 2, 3, 0};

    // Reset with every requester asking
    applyStimulus(1'b1, 4'hF, 32'h0);
    applyStimulus(1'b1, 4'hF, 32'h0);
    checkOutput("rst_gnt",   32'(gnt),   32'h0);
    checkOutput("rst_q",     32'(q),     32'h0);
    checkOutput("rst_q_wr",  32'(q_wr),  32'h0);
    checkOutput("rst_owner", 32'(owner), 32'h0);
    applyStimulus(1'b0, 4'hF, 32'h0);
    applyStimulus(1'b0, 4'h0, 32'h0);
    checkOutput("first_gnt", 32'(gnt), 32'h1);
    applyStimulus(1'b0, 4'h0, 32'h0);

    // Single transfer on requester 2
    applyStimulus(1'b0, 4'b0100, 32'h00A1_0000);
    applyStimulus(1'b0, 4'b0100, 32'h00A1_0000);
    checkOutput("single_gnt", 32'(gnt), 32'h4);
    applyStimulus(1'b0, 4'b0100, 32'h00A2_0000);
    checkOutput("single_q1", 32'(q), 32'hA1);
    checkOutput("single_wr1", 32'(q_wr), 32'h1);
    applyStimulus(1'b0, 4'b0100, 32'h00A3_0000);
    applyStimulus(1'b0, 4'b0000, 32'h5555_5555);
    checkOutput("single_q3", 32'(q), 32'hA3);
    applyStimulus(1'b0, 4'b0000, 32'h5555_5555);
    checkOutput("single_rel_gnt", 32'(gnt), 32'h0);
    checkOutput("single_hold_q", 32'(q), 32'hA3);
    checkOutput("single_rel_wr", 32'(q_wr), 32'h0);

    // Pointer wrap: grant 3, then 0 and 3 together must pick 0
    applyStimulus(1'b0, 4'b1000, 32'h7700_0000);
    applyStimulus(1'b0, 4'b1000, 32'h7800_0000);
    applyStimulus(1'b0, 4'b0000, 32'h0);
    applyStimulus(1'b0, 4'b1001, 32'h0);
    applyStimulus(1'b0, 4'b0000, 32'h0);
    checkOutput("wrap_gnt", 32'(gnt), 32'h1);
    applyStimulus(1'b0, 4'b0000, 32'h0);

    // Fairness: each grantee drops req for one cycle after two loads
    applyStimulus(1'b1, 4'h0, 32'h0);
    seen = 1'b0; gap = 0; prev = 4'h0;
    for (int c = 0; c < 24; c++) begin
      rq = 4'hF;
      if (m_busy && m_cnt == 2) rq[m_owner[1:0]] = 1'b0;
      applyStimulus(1'b0, rq, $urandom);
      if (gnt != 4'h0) begin
        if (prev == 4'h0) begin
          if (seen) gaps.push_back(gap);
          order.push_back(int'(owner));
          seen = 1'b1;
          gap = 0;
        end
      end else if (seen) begin
        gap++;
      end
      prev = gnt;
    end
    checkOutput("fair_count", 32'(order.size() >= 5), 32'h1);
    for (int k = 0; k < 5; k++)
      checkOutput("fair_order", (k < order.size()) ? 32'(order[k]) : 32'hFFFF_FFFF, 32'(exp_order[k]));
    for (int k = 0; k < 4; k++)
      checkOutput("fair_gap", (k < gaps.size()) ? 32'(gaps[k]) : 32'hFFFF_FFFF, 32'h1);
    applyStimulus(1'b0, 4'h0, 32'h0);
    applyStimulus(1'b0, 4'h0, 32'h0);

    // Reset during the second grant cycle of requester 1
    applyStimulus(1'b0, 4'b0010, 32'h0000_3C00);
    applyStimulus(1'b0, 4'b0010, 32'h0000_3D00);
    applyStimulus(1'b1, 4'b0010, 32'h0000_3E00);
    applyStimulus(1'b0, 4'b0010, 32'h0000_3F00);
    checkOutput("midrst_gnt", 32'(gnt), 32'h0);
    checkOutput("midrst_q", 32'(q), 32'h0);
    checkOutput("midrst_q_wr", 32'(q_wr), 32'h0);
    applyStimulus(1'b0, 4'b0000, 32'h0);
    checkOutput("midrst_regnt", 32'(gnt), 32'h2);
    applyStimulus(1'b0, 4'b0000, 32'h0);

    // Long hold with requesters 0 and 1 both asking
    for (int c = 0; c < 24; c++) begin
      applyStimulus(1'b0, 4'b0011, $urandom);
      if (c == 11) begin
`ifdef DREG_ARB_TIMEOUT_EN
        checkOutput("long_gnt", 32'(gnt), 32'h2);
`else
        checkOutput("long_gnt", 32'(gnt), 32'h1);
`endif
      end
    end
`ifndef DREG_ARB_TIMEOUT_EN
    checkOutput("long_hold_gnt", 32'(gnt), 32'h1);
`endif
    applyStimulus(1'b0, 4'h0, 32'h0);
    applyStimulus(1'b0, 4'h0, 32'h0);

    @(negedge clk);
    while (sb.size() != 0) scoreboardCheck();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
